// File: rtl/stopwatch_up.sv
// rtl/stopwatch_up.sv - MM:SS BCD up-counting stopwatch with run/pause/done control
// Optional lap display freeze compiled in with STOPWATCH_LAP_EN.
module stopwatch_up (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] out_second_unit,
  output logic [3:0] out_second_tens,
  output logic [3:0] out_minute_unit,
  output logic [3:0] out_minute_tens,
  output logic       running,
  output logic       overflow,
  output logic       lap_active
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [15:0] COUNT_MAX = 16'h5959;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d, count_inc;
  logic        overflow_q, overflow_d;
  logic        running_q, running_d;
  logic        do_inc;

  // Count packed as {minute_tens, minute_unit, second_tens, second_unit}.
  always_comb begin
    count_inc = count_q;
    if (count_q[3:0] != 4'd9) begin
      count_inc[3:0] = count_q[3:0] + 4'd1;
    end else begin
      count_inc[3:0] = 4'd0;
      if (count_q[7:4] != 4'd5) begin
        count_inc[7:4] = count_q[7:4] + 4'd1;
      end else begin
        count_inc[7:4] = 4'd0;
        if (count_q[11:8] != 4'd9) begin
          count_inc[11:8] = count_q[11:8] + 4'd1;
        end else begin
          count_inc[11:8] = 4'd0;
          if (count_q[15:12] != 4'd5) count_inc[15:12] = count_q[15:12] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    do_inc     = 1'b0;
    if (clear) begin
      state_d    = IDLE;
      count_d    = 16'h0000;
      overflow_d = 1'b0;
    end else begin
      // In RUN a tick is counted even when start_stop arrives with it.
      do_inc = (state_q == RUN) && tick;
      if (do_inc) count_d = count_inc;
      case (state_q)
        IDLE:  if (start_stop) state_d = RUN;
        RUN: begin
          if (do_inc && (count_inc == COUNT_MAX)) begin
            state_d    = DONE;
            overflow_d = 1'b1;
          end else if (start_stop) begin
            state_d = PAUSE;
          end
        end
        PAUSE: if (start_stop) state_d = RUN;
        default: state_d = state_q;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 16'h0000;
      overflow_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      running_q  <= running_d;
    end
  end

  assign running  = running_q;
  assign overflow = overflow_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_active_q, lap_active_d;
  logic [15:0] disp_q, disp_d;

  // disp_q tracks the live count and doubles as the frozen lap capture.
  always_comb begin
    lap_active_d = lap_active_q;
    disp_d       = count_d;
    if (clear) lap_active_d = 1'b0;
    else if (lap) lap_active_d = !lap_active_q;
    if (lap_active_d) disp_d = lap_active_q ? disp_q : count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_active_q <= 1'b0;
      disp_q       <= 16'h0000;
    end else begin
      lap_active_q <= lap_active_d;
      disp_q       <= disp_d;
    end
  end

  assign lap_active      = lap_active_q;
  assign out_second_unit = disp_q[3:0];
  assign out_second_tens = disp_q[7:4];
  assign out_minute_unit = disp_q[11:8];
  assign out_minute_tens = disp_q[15:12];
`else
  logic lap_unused;
  assign lap_unused      = lap;
  assign lap_active      = 1'b0;
  assign out_second_unit = count_q[3:0];
  assign out_second_tens = count_q[7:4];
  assign out_minute_unit = count_q[11:8];
  assign out_minute_tens = count_q[15:12];
`endif

endmodule

// File: tb/tb_stopwatch_up.sv
// tb/tb_stopwatch_up.sv - directed self-checking bench for stopwatch_up
module tb_stopwatch_up;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, tick, start_stop, clear, lap;
  logic [3:0] su, st, mu, mt;
  logic       running, overflow, lap_active;
  logic [15:0] disp;
  int checks = 0;
  int failures = 0;

  stopwatch_up dut (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .out_second_unit(su), .out_second_tens(st), .out_minute_unit(mu), .out_minute_tens(mt),
    .running(running), .overflow(overflow), .lap_active(lap_active)
  );

  always #5 clk = ~clk;
  assign disp = {mt, mu, st, su};

  task automatic step(input logic ss, input logic tk, input logic clr, input logic lp);
    start_stop = ss; tick = tk; clear = clr; lap = lp;
    @(posedge clk); #1;
    start_stop = 1'b0; tick = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; tick = 1'b1; start_stop = 1'b1; lap = 1'b1; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; tick = 1'b0; start_stop = 1'b0; lap = 1'b0;
    checks++;
    if ({disp, running, overflow, lap_active} !== 19'd0) begin
      failures++;
      $display("FAIL reset_state disp=%h run=%b ovf=%b lap=%b expected all zero",
               disp, running, overflow, lap_active);
    end
  endtask

  task automatic test_basic_count;
    step(1, 0, 0, 0);
    checks++;
    if (running !== 1'b1 || disp !== 16'h0000) begin
      failures++;
      $display("FAIL basic_start run=%b disp=%h expected run=1 disp=0000", running, disp);
    end
    ticks(61);
    checks++;
    if (disp !== 16'h0101 || running !== 1'b1 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_count disp=%h run=%b ovf=%b expected 0101 1 0", disp, running, overflow);
    end
  endtask

  task automatic test_carry;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    ticks(599);
    checks++;
    if (disp !== 16'h0959) begin
      failures++;
      $display("FAIL carry_pre disp=%h expected 0959", disp);
    end
    step(0, 1, 0, 0);
    checks++;
    if (disp !== 16'h1000) begin
      failures++;
      $display("FAIL carry_cascade disp=%h expected 1000", disp);
    end
  endtask

  task automatic test_saturation;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    ticks(3598);
    checks++;
    if (disp !== 16'h5958 || overflow !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL sat_pre disp=%h ovf=%b run=%b expected 5958 0 1", disp, overflow, running);
    end
    ticks(2);
    checks++;
    if (disp !== 16'h5959 || overflow !== 1'b1 || running !== 1'b0) begin
      failures++;
      $display("FAIL sat_hold disp=%h ovf=%b run=%b expected 5959 1 0", disp, overflow, running);
    end
    step(1, 1, 0, 0);
    checks++;
    if (disp !== 16'h5959 || running !== 1'b0 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL sat_done_ignore disp=%h run=%b ovf=%b expected 5959 0 1", disp, running, overflow);
    end
    step(0, 0, 1, 0);
    checks++;
    if (disp !== 16'h0000 || overflow !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear disp=%h ovf=%b run=%b expected 0000 0 0", disp, overflow, running);
    end
    step(1, 0, 0, 0);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL sat_idle_after_clear run=%b expected 1", running);
    end
    step(0, 0, 1, 0);
  endtask

  task automatic test_pause_simul;
    step(1, 1, 0, 0);
    checks++;
    if (disp !== 16'h0000 || running !== 1'b1) begin
      failures++;
      $display("FAIL idle_ss_tick disp=%h run=%b expected 0000 1", disp, running);
    end
    ticks(5);
    step(1, 1, 0, 0);
    checks++;
    if (disp !== 16'h0006 || running !== 1'b0) begin
      failures++;
      $display("FAIL run_ss_tick disp=%h run=%b expected 0006 0", disp, running);
    end
    ticks(3);
    checks++;
    if (disp !== 16'h0006 || running !== 1'b0) begin
      failures++;
      $display("FAIL pause_hold disp=%h run=%b expected 0006 0", disp, running);
    end
    step(1, 1, 0, 0);
    checks++;
    if (disp !== 16'h0006 || running !== 1'b1) begin
      failures++;
      $display("FAIL pause_ss_tick disp=%h run=%b expected 0006 1", disp, running);
    end
    step(0, 1, 0, 0);
    checks++;
    if (disp !== 16'h0007) begin
      failures++;
      $display("FAIL resume_count disp=%h expected 0007", disp);
    end
  endtask

  task automatic test_lap;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    ticks(10);
    step(0, 0, 0, 1);
    checks++;
    if (disp !== 16'h0010 || lap_active !== LAP_EN) begin
      failures++;
      $display("FAIL lap_latch disp=%h lap=%b expected 0010 %b", disp, lap_active, LAP_EN);
    end
    ticks(5);
    checks++;
    if (disp !== (LAP_EN ? 16'h0010 : 16'h0015) || lap_active !== LAP_EN) begin
      failures++;
      $display("FAIL lap_frozen disp=%h lap=%b expected %h %b", disp, lap_active,
               LAP_EN ? 16'h0010 : 16'h0015, LAP_EN);
    end
    step(0, 0, 0, 1);
    checks++;
    if (disp !== 16'h0015 || lap_active !== 1'b0) begin
      failures++;
      $display("FAIL lap_release disp=%h lap=%b expected 0015 0", disp, lap_active);
    end
    step(0, 1, 0, 1);
    checks++;
    if (disp !== (LAP_EN ? 16'h0015 : 16'h0016) || lap_active !== LAP_EN) begin
      failures++;
      $display("FAIL lap_pre_increment disp=%h lap=%b expected %h %b", disp, lap_active,
               LAP_EN ? 16'h0015 : 16'h0016, LAP_EN);
    end
    ticks(1);
    step(0, 0, 0, 1);
    checks++;
    if (disp !== 16'h0017 || lap_active !== 1'b0) begin
      failures++;
      $display("FAIL lap_count_continues disp=%h lap=%b expected 0017 0", disp, lap_active);
    end
  endtask

  task automatic test_reset_mid;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    ticks(754);
    step(0, 0, 0, 1);
    checks++;
    if (disp !== 16'h1234 || lap_active !== LAP_EN) begin
      failures++;
      $display("FAIL mid_pre disp=%h lap=%b expected 1234 %b", disp, lap_active, LAP_EN);
    end
    rst = 1'b1; tick = 1'b1; lap = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; tick = 1'b0; lap = 1'b0;
    checks++;
    if ({disp, running, overflow, lap_active} !== 19'd0) begin
      failures++;
      $display("FAIL mid_reset disp=%h run=%b ovf=%b lap=%b expected all zero",
               disp, running, overflow, lap_active);
    end
    step(0, 1, 0, 0);
    checks++;
    if (disp !== 16'h0000 || running !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_idle disp=%h run=%b expected 0000 0", disp, running);
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    test_reset();
    test_basic_count();
    test_carry();
    test_saturation();
    test_pause_simul();
    test_lap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_up.md
STOPWATCH_UP -- requirements
Module: stopwatch_up

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset, named clk and rst.
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle count strobe, one per second
- start_stop  in  1  one-cycle pulse that toggles run/pause
- clear  in  1  one-cycle pulse that returns to 00:00 idle
- lap  in  1  one-cycle pulse that toggles the display freeze
- out_second_unit  out  4  BCD 0-9
- out_second_tens  out  4  BCD 0-5
- out_minute_unit  out  4  BCD 0-9
- out_minute_tens  out  4  BCD 0-5
- running  out  1  high in RUN
- overflow  out  1  sticky flag, 59:59 reached
- lap_active  out  1  display frozen
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The block SHALL hold a 4-digit BCD count MM:SS in the range 00:00 to 59:59, counting up.
REQ-005 States SHALL be IDLE, RUN, PAUSE and DONE.
REQ-006 Transitions SHALL be:
- IDLE -start_stop-> RUN
- RUN -start_stop-> PAUSE
- PAUSE -start_stop-> RUN
- RUN -count reaches 59:59-> DONE
- any state -clear-> IDLE
REQ-007 start_stop in DONE SHALL be ignored.
REQ-008 The count SHALL increment by 1 on a clock edge only when the state is RUN and tick=1; the new value is visible the next cycle (latency 1).
REQ-009 Cascade carries SHALL follow these rules:
- second_unit 9->0 carries into second_tens
- second_tens 5->0 carries into minute_unit
- minute_unit 9->0 carries into minute_tens
- all carries resolve in a single edge; no intermediate digit value is ever visible
REQ-010 On an increment to 59:59 the count SHALL hold at 59:59, overflow SHALL be set to 1, and the state SHALL go to DONE on the same edge.
REQ-011 In DONE, ticks SHALL be ignored.
REQ-012 overflow SHALL stay set until clear or rst.
REQ-013 Priority per cycle SHALL be rst > clear > start_stop > lap > tick.
REQ-014 clear SHALL zero the count, overflow and lap_active, and enter IDLE on the same edge.
REQ-015 start_stop and tick in the same cycle SHALL behave as follows:
- from IDLE or PAUSE: the tick is not counted; RUN begins next cycle
- from RUN: the tick is counted, then the state goes to PAUSE
REQ-016 running SHALL equal (state==RUN), registered alongside the state.
REQ-017 When lap_active=0, the out_* digits SHALL track the live count.
REQ-018 A lap pulse with lap_active=0 SHALL latch the live count as it stands before that edge's increment, set lap_active=1, and freeze the out_* digits.
REQ-019 A lap pulse with lap_active=1 SHALL clear lap_active; the out_* digits show the live count the next cycle.
REQ-020 Internal counting SHALL continue while lap_active=1.
REQ-021 lap SHALL be accepted in every state.
REQ-022 Digits SHALL never hold non-BCD values, and tens digits SHALL never exceed 5.

Reset
REQ-023 On rst=1 at a clock edge, the block SHALL enter IDLE and set every output to zero: all four digits, running, overflow and lap_active.
REQ-024 rst SHALL override all other inputs, including mid-count, in DONE, or while lap_active=1.
REQ-025 Inputs SHALL be ignored on the reset edge.

Configuration
REQ-026 The lap feature SHALL be compiled in only when the macro STOPWATCH_LAP_EN is defined.
REQ-027 With STOPWATCH_LAP_EN defined, the block SHALL implement REQ-017 to REQ-021.
REQ-028 Without STOPWATCH_LAP_EN:
- the lap port SHALL remain present and be ignored
- lap_active SHALL be tied to 0
- the out_* digits SHALL always track the live count
- no lap latch registers SHALL be generated

Verification
REQ-029 Basic count:
- stimulus: rst; start_stop; then 61 ticks
- required response: out = 01:01; running=1; overflow=0
REQ-030 Carry cascade:
- stimulus: run to 09:59; one more tick
- required response: out = 10:00 the next cycle, with no intermediate values
REQ-031 Saturation:
- stimulus: run to 59:58; 2 ticks; then start_stop
- required response: out = 59:59; overflow=1; DONE; running=0; start_stop ignored
- follow-up: clear gives 00:00, overflow=0, IDLE
REQ-032 Pause and simultaneous events:
- stimulus: at 00:05 in RUN, assert start_stop and tick together; then 3 ticks
- required response: out = 00:06 with PAUSE held through the 3 ticks
- follow-up: start_stop plus tick together from PAUSE leaves the count at 00:06
REQ-033 Lap (STOPWATCH_LAP_EN defined):
- stimulus: lap at 00:10; 5 ticks
- required response: out = 00:10 and lap_active=1
- follow-up: a second lap gives out = 00:15
- without the macro: out = 00:15 throughout and lap_active=0
REQ-034 Reset mid-operation:
- stimulus: rst at 12:34 in RUN with lap_active=1
- required response: all outputs 0 and IDLE the next cycle; a tick in that same cycle is ignored
